lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the core's execute stage and the data RAM.
- Accepts one memory request at a time over a valid/ready handshake and drives the RAM strobe/size/address/data signals.
- Performs all load lane extraction and sign/zero extension itself; the RAM is only ever read as aligned words.
- Splits halfword stores at byte offset 2 into two byte writes, because the RAM drops halfword writes at that offset.
- Returns one response pulse per request, flagging misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 32004: size of the RAM byte space; any access whose last byte is at or above this address is an error.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores use 000/001/010
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  misaligned or out-of-range; valid with rsp_valid
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- mem_read  out  1  RAM read strobe
- mem_write  out  1  RAM write strobe
- mem_size  out  3  000 byte, 001 half, 010 word
- mem_addr  out  32  RAM byte address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, registered, valid the cycle after mem_read

Behaviour:
- Reset (async, resetn=0):
  - state = IDLE.
  - req_ready=1; all other outputs 0.
  - An in-flight access is abandoned and no response is issued.
- All outputs are registered.
- Accept: at the edge where req_valid && req_ready, the request is latched and req_ready drops. The accept edge is E0; cycle n follows edge En-1.
- Error check (at accept):
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]!=0 is misaligned.
  - Any access with addr+bytes-1 >= MEM_BYTES is out of range.
  - Unused funct3 codes (011, 110, 111, and 1xx with req_we=1) are errors.
  - On error: ERR state, rsp_valid=1 and rsp_err=1 in cycle 1, no mem strobes ever asserted, then IDLE.
- State machine (enum in package): IDLE, ACCESS, LD_WAIT, ST_HI, RESP, ERR.
- Loads:
  - ACCESS (cycle 1): mem_read=1, mem_size=010, mem_addr = addr & ~3.
  - LD_WAIT (cycle 2): mem_read=0; mem_rdata is sampled only in this state, because RAM output holds stale data otherwise.
  - The lane is selected by addr[1:0] and extended per funct3; the result is registered.
  - RESP (cycle 3): rsp_valid=1 with rsp_rdata. Load latency is 3 cycles from accept.
- Stores:
  - SB: ACCESS with mem_write=1, mem_size=000, mem_addr=addr, mem_wdata=req_wdata.
  - SW: ACCESS with mem_size=010, mem_addr=addr, mem_wdata=req_wdata.
  - SH at offset 0: ACCESS with mem_size=001, mem_addr=addr, mem_wdata=req_wdata.
  - For all three: rsp_valid in cycle 2.
  - SH at offset 2, cycle 1: byte write to addr with wdata[7:0].
  - SH at offset 2, cycle 2 (ST_HI): byte write to addr+1 with mem_wdata[7:0]=req_wdata[15:8]; rsp_valid in cycle 3.
- Strobes are high for exactly one cycle per RAM access. mem_read and mem_write are never high together.
- rsp_valid has no backpressure: the core must take it.
- req_ready returns high the cycle after rsp_valid. Back-to-back requests therefore have a 1-cycle bubble minimum.
- Requests arriving while req_ready=0 are ignored (not latched).

Decomposition:
- lsu_pkg holds:
  - funct3 constants
  - MEM_SIZE_BYTE/HALF/WORD encodings
  - lsu_state_t enum
- Sub-module load_align (combinational): inputs word, offset, funct3; output extended 32-bit data. It is reused by any future cache path.

Test Plan:
- Preload 0x100 = 0x8877F6A5; LB 0x101 accepted at E0 -> cycle 1 mem_read=1, mem_addr=0x100, mem_size=010; cycle 3 rsp_valid=1, rsp_rdata=0xFFFFFFF6, rsp_err=0.
- LH 0x102 -> 0xFFFF8877; LHU 0x102 -> 0x00008877; LBU 0x100 -> 0x000000A5; LW 0x100 -> 0x8877F6A5.
- SH 0x102 wdata=0x1234ABCD -> cycle 1 byte write addr 0x102 data 0xCD, cycle 2 byte write addr 0x103 data 0xAB, cycle 3 rsp_valid; then LW 0x100 -> 0xABCDF6A5.
- LW 0x102, LH 0x101, SW 0x7D04 (MEM_BYTES=32004) -> rsp_err=1 in cycle 1; mem_read and mem_write stay 0 throughout.
- Assert resetn=0 during LD_WAIT -> all outputs 0 immediately, no rsp_valid; after release req_ready=1 and a following SB 0x100 data 0x11 completes, and LW 0x100 returns 0x8877F611.
- Hold req_valid high continuously with new requests -> exactly one accept per response, and the req_valid presented while busy is not latched.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and state type for the load/store unit
// Contents: funct3 load/store codes, RAM access size encodings, lsu_state_t.
package lsu_pkg;

  // Stores reuse the low three codes (SB=000, SH=001, SW=010).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] MEM_SIZE_BYTE = 3'b000;
  localparam logic [2:0] MEM_SIZE_HALF = 3'b001;
  localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    LD_WAIT,
    ST_HI,
    RESP,
    ERR
  } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts a byte/half lane from an aligned word and extends it
// Ports:
//   i_word   : aligned 32-bit word read from RAM
//   i_offset : byte offset of the access inside the word
//   i_funct3 : load type (LB/LH/LW/LBU/LHU)
//   o_data   : sign- or zero-extended result
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'(i_word >> {i_offset, 3'b000});
    // Halfword loads are only ever issued at offset 0 or 2.
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h000000, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit between execute stage and data RAM
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_we/req_funct3/req_addr/req_wdata : request fields
//   rsp_valid/rsp_err/rsp_rdata : one-cycle response pulse
//   mem_read/mem_write/mem_size/mem_addr/mem_wdata : RAM command (all registered)
//   mem_rdata                   : RAM read data, valid the cycle after mem_read
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32004,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_size,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned AW1 = ADDR_W + 1;

  lsu_state_t        r_state, w_state_nx;
  logic              r_req_ready, w_req_ready_nx;
  logic              r_rsp_valid, w_rsp_valid_nx;
  logic              r_rsp_err, w_rsp_err_nx;
  logic [31:0]       r_rsp_rdata, w_rsp_rdata_nx;
  logic              r_mem_read, w_mem_read_nx;
  logic              r_mem_write, w_mem_write_nx;
  logic [2:0]        r_mem_size, w_mem_size_nx;
  logic [31:0]       r_mem_addr, w_mem_addr_nx;
  logic [31:0]       r_mem_wdata, w_mem_wdata_nx;

  // Latched request fields.
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic              r_split;
  logic [7:0]        r_wdata_hi;

  logic              w_accept;
  logic              w_split;
  logic [2:0]        w_bytes;
  logic              w_misalign;
  logic              w_bad_f3;
  logic [AW1-1:0]    w_last;
  logic              w_oor;
  logic              w_err;
  logic [31:0]       w_load_data;

  assign w_accept = req_valid && r_req_ready;
  // The RAM drops halfword writes at offset 2, so those become two byte writes.
  assign w_split  = req_we && (req_funct3 == F3_LH) && (req_addr[1:0] == 2'b10);

  always_comb begin
    w_bytes    = 3'd1;
    w_misalign = 1'b0;
    w_bad_f3   = 1'b0;
    case (req_funct3)
      F3_LB, F3_LBU: w_bytes = 3'd1;
      F3_LH, F3_LHU: begin
        w_bytes    = 3'd2;
        w_misalign = req_addr[0];
      end
      F3_LW: begin
        w_bytes    = 3'd4;
        w_misalign = |req_addr[1:0];
      end
      default: w_bad_f3 = 1'b1;
    endcase
    if (req_we && req_funct3[2]) begin
      w_bad_f3 = 1'b1;
    end
  end

  // One extra bit so an access wrapping past the top of the address space still flags.
  assign w_last = {1'b0, req_addr} + AW1'(w_bytes) - AW1'(1);
  assign w_oor  = (w_last >= AW1'(MEM_BYTES));
  assign w_err  = w_bad_f3 | w_misalign | w_oor;

  load_align u_load_align (
    .i_word   (mem_rdata),
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_data   (w_load_data)
  );

  // Every output is computed for the state being entered and registered with it.
  always_comb begin
    w_state_nx     = r_state;
    w_req_ready_nx = 1'b0;
    w_rsp_valid_nx = 1'b0;
    w_rsp_err_nx   = 1'b0;
    w_rsp_rdata_nx = 32'h0;
    w_mem_read_nx  = 1'b0;
    w_mem_write_nx = 1'b0;
    w_mem_size_nx  = MEM_SIZE_BYTE;
    w_mem_addr_nx  = 32'h0;
    w_mem_wdata_nx = 32'h0;
    case (r_state)
      IDLE: begin
        w_req_ready_nx = 1'b1;
        if (w_accept) begin
          w_req_ready_nx = 1'b0;
          if (w_err) begin
            w_state_nx     = ERR;
            w_rsp_valid_nx = 1'b1;
            w_rsp_err_nx   = 1'b1;
          end else if (req_we) begin
            w_state_nx     = ACCESS;
            w_mem_write_nx = 1'b1;
            // Valid store funct3 codes coincide with the RAM size encoding.
            w_mem_size_nx  = w_split ? MEM_SIZE_BYTE : req_funct3;
            w_mem_addr_nx  = 32'(req_addr);
            w_mem_wdata_nx = req_wdata;
          end else begin
            w_state_nx     = ACCESS;
            w_mem_read_nx  = 1'b1;
            w_mem_size_nx  = MEM_SIZE_WORD;
            w_mem_addr_nx  = 32'(req_addr) & ~32'd3;
          end
        end
      end
      ACCESS: begin
        if (!r_we) begin
          w_state_nx = LD_WAIT;
        end else if (r_split) begin
          w_state_nx     = ST_HI;
          w_mem_write_nx = 1'b1;
          w_mem_size_nx  = MEM_SIZE_BYTE;
          w_mem_addr_nx  = 32'(r_addr + ADDR_W'(1));
          w_mem_wdata_nx = {24'h000000, r_wdata_hi};
        end else begin
          w_state_nx     = RESP;
          w_rsp_valid_nx = 1'b1;
        end
      end
      LD_WAIT: begin
        w_state_nx     = RESP;
        w_rsp_valid_nx = 1'b1;
        w_rsp_rdata_nx = w_load_data;
      end
      ST_HI: begin
        w_state_nx     = RESP;
        w_rsp_valid_nx = 1'b1;
      end
      default: begin
        w_state_nx     = IDLE;
        w_req_ready_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_size  <= MEM_SIZE_BYTE;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_we        <= 1'b0;
      r_f3        <= F3_LB;
      r_addr      <= '0;
      r_split     <= 1'b0;
      r_wdata_hi  <= 8'h00;
    end else begin
      r_state     <= w_state_nx;
      r_req_ready <= w_req_ready_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_err   <= w_rsp_err_nx;
      r_rsp_rdata <= w_rsp_rdata_nx;
      r_mem_read  <= w_mem_read_nx;
      r_mem_write <= w_mem_write_nx;
      r_mem_size  <= w_mem_size_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      if (w_accept) begin
        r_we       <= req_we;
        r_f3       <= req_funct3;
        r_addr     <= req_addr;
        r_split    <= w_split;
        r_wdata_hi <= req_wdata[15:8];
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_size  = r_mem_size;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with RAM model and reference model
module tb_lsu_ctrl;

  localparam int MEMB = 32004;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, mem_read, mem_write;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_size;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_err = 0;

  lsu_ctrl #(.MEM_BYTES(MEMB), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: registered word reads, garbage when not reading, drops halfword writes at offset 2.
  logic [7:0]  ram [0:32767];
  bit          ram_clr = 1'b0;
  logic [14:0] ram_a;
  always @(posedge clk) begin
    if (!ram_clr) begin
      for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
      ram_clr = 1'b1;
    end
    ram_a = mem_addr[14:0];
    if (mem_write) begin
      case (mem_size)
        3'b000: ram[ram_a] = mem_wdata[7:0];
        3'b001: if (ram_a[1:0] != 2'b10) begin
          ram[ram_a] = mem_wdata[7:0];
          ram[ram_a + 15'd1] = mem_wdata[15:8];
        end
        default: for (int i = 0; i < 4; i++) ram[ram_a + 15'(i)] = 8'(mem_wdata >> (8 * i));
      endcase
    end
    if (mem_read) begin
      ram_a[1:0] = 2'b00;
      mem_rdata <= {ram[ram_a + 15'd3], ram[ram_a + 15'd2], ram[ram_a + 15'd1], ram[ram_a]};
    end else begin
      mem_rdata <= $urandom;
    end
  end

  int overlap_cnt = 0;
  int dbl_rd_cnt = 0;
  bit prev_rd = 1'b0;
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap_cnt++;
    if (mem_read && prev_rd) dbl_rd_cnt++;
    prev_rd = mem_read;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // Reference model of memory contents.
  logic [7:0] mdl [0:32767];

  function automatic int ref_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int n = ref_bytes(f3);
    if (n == 0 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2])) return 1'b1;
    if ((addr % n) != 0) return 1'b1;
    if (longint'(addr) + n - 1 >= MEMB) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
    int n = ref_bytes(f3);
    longint v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(mdl[(addr + i) & 32'h7FFF]);
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [31:0] wd, input int n);
    for (int i = 0; i < n; i++) mdl[(addr + i) & 32'h7FFF] = 8'(wd >> (8 * i));
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observations of the last request.
  int          lat, nrd, nwr, rd_cyc;
  logic        o_err;
  logic [31:0] o_rdata, rd_addr;
  logic [2:0]  rd_size;
  int          wr_cyc  [4];
  logic [31:0] wr_addr [4];
  logic [31:0] wr_data [4];
  logic [2:0]  wr_size [4];

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    chk("ready_before_req", {rsp_valid, req_ready}, 2'b01);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rd_cyc = 0; o_err = 1'b0; o_rdata = 32'h0; rd_addr = 32'h0; rd_size = 3'h0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (mem_read) begin
        nrd++; rd_cyc = c; rd_addr = mem_addr; rd_size = mem_size;
      end
      if (mem_write) begin
        if (nwr < 4) begin
          wr_cyc[nwr] = c; wr_addr[nwr] = mem_addr; wr_data[nwr] = mem_wdata; wr_size[nwr] = mem_size;
        end
        nwr++;
      end
      if (rsp_valid) begin
        lat = c; o_err = rsp_err; o_rdata = rsp_rdata;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input string tag);
    bit e;
    int n, exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_data;
    e = ref_err(we, f3, addr);
    n = ref_bytes(f3);
    if (e) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0; exp_data = 32'h0;
    end else if (!we) begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0; exp_data = ref_load(f3, addr);
    end else begin
      exp_lat = (n == 2 && addr[1:0] == 2'b10) ? 3 : 2;
      exp_wr  = exp_lat - 1;
      exp_rd  = 0; exp_data = 32'h0;
    end
    do_req(we, f3, addr, wd);
    chk({tag, "/err"}, o_err, e);
    chk({tag, "/latency"}, lat, exp_lat);
    chk({tag, "/rdata"}, o_rdata, exp_data);
    chk({tag, "/reads"}, nrd, exp_rd);
    chk({tag, "/writes"}, nwr, exp_wr);
    if (!e && we) ref_store(addr, wd, n);
  endtask

  int          acc, nrsp;
  int          rsp_c [2];
  logic [31:0] rsp_d [2];
  logic [31:0] exp_a, exp_b;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  int          r_n;

  initial begin
    for (int i = 0; i < 32768; i++) mdl[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", {req_ready, rsp_valid, rsp_err, mem_read, mem_write, mem_size}, 8'b1000_0000);
    chk("reset_data", {rsp_rdata, mem_addr, mem_wdata}, 96'h0);
    resetn = 1'b1;

    // Preload through the DUT
    run_req(1'b1, 3'b010, 32'h100, 32'h8877F6A5, "sw_preload");
    chk("sw_preload/addr", {wr_size[0], wr_addr[0], wr_data[0]}, {3'b010, 32'h100, 32'h8877F6A5});

    // Loads with lane extraction
    run_req(1'b0, 3'b000, 32'h101, 32'h0, "lb_101");
    chk("lb_101/strobe", {rd_cyc[3:0], rd_size, rd_addr}, {4'd1, 3'b010, 32'h100});
    chk("lb_101/value", o_rdata, 32'hFFFFFFF6);
    run_req(1'b0, 3'b001, 32'h102, 32'h0, "lh_102");
    chk("lh_102/value", o_rdata, 32'hFFFF8877);
    run_req(1'b0, 3'b101, 32'h102, 32'h0, "lhu_102");
    chk("lhu_102/value", o_rdata, 32'h00008877);
    run_req(1'b0, 3'b100, 32'h100, 32'h0, "lbu_100");
    chk("lbu_100/value", o_rdata, 32'h000000A5);
    run_req(1'b0, 3'b010, 32'h100, 32'h0, "lw_100");
    chk("lw_100/value", o_rdata, 32'h8877F6A5);

    // Errors and range boundary
    run_req(1'b0, 3'b010, 32'h102, 32'h0, "lw_102_misalign");
    chk("lw_102/err_const", o_err, 1'b1);
    run_req(1'b0, 3'b001, 32'h101, 32'h0, "lh_101_misalign");
    chk("lh_101/err_const", o_err, 1'b1);
    run_req(1'b1, 3'b010, 32'h7D04, 32'hDEADBEEF, "sw_7d04_oor");
    chk("sw_7d04/err_const", o_err, 1'b1);
    run_req(1'b1, 3'b010, 32'h7D00, 32'hCAFEF00D, "sw_7d00_last");
    run_req(1'b0, 3'b100, 32'h7D03, 32'h0, "lbu_7d03_last");
    chk("lbu_7d03/value", o_rdata, 32'h000000CA);
    run_req(1'b0, 3'b001, 32'h7D03, 32'h0, "lh_7d03");
    run_req(1'b0, 3'b011, 32'h100, 32'h0, "f3_011");
    run_req(1'b1, 3'b100, 32'h100, 32'h0, "st_f3_100");
    run_req(1'b0, 3'b111, 32'h100, 32'h0, "f3_111");

    // Reset asserted during LD_WAIT
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_ctl", {req_ready, rsp_valid, rsp_err, mem_read, mem_write, mem_size}, 8'b1000_0000);
    chk("rst_mid_data", {rsp_rdata, mem_addr, mem_wdata}, 96'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) nrsp++;
      @(negedge clk);
    end
    chk("rst_no_rsp", nrsp, 0);
    chk("rst_ready", req_ready, 1'b1);
    run_req(1'b1, 3'b000, 32'h100, 32'h00000011, "sb_after_rst");
    run_req(1'b0, 3'b010, 32'h100, 32'h0, "lw_after_sb");
    chk("lw_after_sb/value", o_rdata, 32'h8877F611);

    // Halfword store at offset 2 splits into two byte writes
    run_req(1'b1, 3'b001, 32'h102, 32'h1234ABCD, "sh_102");
    chk("sh_102/wr0", {wr_cyc[0][3:0], wr_size[0], wr_addr[0], wr_data[0][7:0]}, {4'd1, 3'b000, 32'h102, 8'hCD});
    chk("sh_102/wr1", {wr_cyc[1][3:0], wr_size[1], wr_addr[1], wr_data[1][7:0]}, {4'd2, 3'b000, 32'h103, 8'hAB});
    run_req(1'b0, 3'b010, 32'h100, 32'h0, "lw_after_sh");
    chk("lw_after_sh/value", o_rdata, 32'hABCDF611);
    run_req(1'b1, 3'b001, 32'h104, 32'h00005A3C, "sh_104");
    chk("sh_104/wr0", {wr_size[0], wr_addr[0], wr_data[0][15:0]}, {3'b001, 32'h104, 16'h5A3C});

    // req_valid held high: busy-time request is not latched
    exp_a = ref_load(3'b010, 32'h100);
    exp_b = ref_load(3'b100, 32'h101);
    @(negedge clk);
    chk("held/ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(negedge clk);
    req_funct3 = 3'b100; req_addr = 32'h101;
    acc = 1; nrsp = 0; rsp_c[0] = 0; rsp_c[1] = 0; rsp_d[0] = 32'h0; rsp_d[1] = 32'h0;
    for (int c = 1; c <= 16 && nrsp < 2; c++) begin
      if (req_ready && req_valid) acc++;
      if (rsp_valid) begin
        rsp_d[nrsp] = rsp_rdata; rsp_c[nrsp] = c; nrsp++;
      end
      if (nrsp == 2) req_valid = 1'b0;
      else @(negedge clk);
    end
    chk("held/accepts", acc, 2);
    chk("held/rsp_cycles", {rsp_c[0][7:0], rsp_c[1][7:0]}, {8'd3, 8'd7});
    chk("held/rsp_a", rsp_d[0], exp_a);
    chk("held/rsp_b", rsp_d[1], exp_b);

    // Randomized traffic against the reference model
    for (int k = 0; k < 120; k++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) r_f3 = 3'($urandom_range(0, 7));
      else if (r_we) r_f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: r_f3 = 3'b000;
          1: r_f3 = 3'b001;
          2: r_f3 = 3'b010;
          3: r_f3 = 3'b100;
          default: r_f3 = 3'b101;
        endcase
      end
      if ($urandom_range(0, 4) == 0) r_addr = 32'(MEMB - 8 + $urandom_range(0, 11));
      else r_addr = 32'h100 + 32'($urandom_range(0, 31));
      r_n = ref_bytes(r_f3);
      if ($urandom_range(0, 3) != 0) begin
        if (r_n == 2) r_addr[0] = 1'b0;
        if (r_n == 4) r_addr[1:0] = 2'b00;
      end
      run_req(r_we, r_f3, r_addr, $urandom, $sformatf("rnd%0d", k));
    end

    @(negedge clk);
    chk("no_rd_wr_overlap", overlap_cnt, 0);
    chk("rd_single_cycle", dbl_rd_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
